// File: rtl/axon_spike_scheduler.sv
// Axon spike scheduler: snapshots one core's axon spike vector on a
// timestep start and streams the set bits as ascending axon-index events.
module axon_spike_scheduler #(
    parameter int NUM_AXONS  = 256,
    parameter int AXON_IDX_W = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic [NUM_AXONS-1:0]  spike_axon_i,
    output logic                  event_valid_o,
    input  logic                  event_ready_i,
    output logic [AXON_IDX_W-1:0] event_axon_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [AXON_IDX_W:0]   spike_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_AXONS-1:0]  pending_q, pending_d;
    logic [AXON_IDX_W:0]   count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [AXON_IDX_W-1:0] low_idx;

    // Priority encoder: index of the lowest pending axon (0 when empty)
    always_comb begin
        low_idx = '0;
        for (int i = NUM_AXONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = AXON_IDX_W'(i);
            end
        end
    end

    // Next-state logic: snapshot on start, retire one axon per handshake
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pending_d = spike_axon_i;
                    count_d   = '0;
                    state_d   = (|spike_axon_i) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                if (event_ready_i) begin
                    pending_d[low_idx] = 1'b0;
                    count_d            = count_q + 1'b1;
                    if (pending_d == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and registered status flags, cleared asynchronously on reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign event_valid_o = (state_q == S_SCAN);
    assign event_axon_o  = low_idx;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign spike_count_o = count_q;

endmodule

// File: doc/axon_spike_scheduler.md
Name: axon_spike_scheduler

Overview:
- Sits directly downstream of the per-core input-spike memory.
- On a timestep start pulse, it snapshots one core's 256-bit axon spike vector.
- It then serialises the set bits into a stream of axon-index events, in ascending order, over a valid/ready handshake to the synapse/neuron core.
- It reports completion and the number of events issued.

Parameters:
- NUM_AXONS, 256, width of the spike vector and number of axons.
- AXON_IDX_W, 8, width of the emitted axon index; must equal clog2(NUM_AXONS).

Ports:
- wb_clk_i  input  1  clock; all state updates on rising edge.
- wb_rst_i  input  1  asynchronous active-high reset.
- start_i  input  1  timestep start pulse; sampled only in IDLE.
- spike_axon_i  input  NUM_AXONS  spike vector from the input memory; bit k = axon k.
- event_valid_o  output  1  an axon event is presented.
- event_ready_i  input  1  consumer accepts the event this cycle.
- event_axon_o  output  AXON_IDX_W  index of the presented axon.
- busy_o  output  1  high in SCAN and DONE.
- done_o  output  1  one-cycle pulse when all events of the timestep are accepted.
- spike_count_o  output  AXON_IDX_W+1  events accepted since the last start; max value 256.

Behaviour:
- Reset (asynchronous, immediate, any state): state=IDLE, pending mask=0, event_valid_o=0, event_axon_o=0, busy_o=0, done_o=0, spike_count_o=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start_i=1 at an edge: pending <= spike_axon_i (snapshot), spike_count_o <= 0.
  - If the snapshot is nonzero, go to SCAN; if it is zero, go to DONE.
  - start_i=0: stay in IDLE.
- Snapshot isolation: changes on spike_axon_i after the start edge have no effect until the next start.
- SCAN:
  - event_valid_o=1 combinationally from state.
  - event_axon_o = index of the lowest set bit of pending, via a combinational priority encoder.
  - First event is visible the cycle after the start edge, giving 1-cycle start-to-valid latency.
- Handshake (valid&&ready at an edge):
  - Clear that bit in pending.
  - Increment spike_count_o.
  - Next index is presented the following cycle, giving 1 event/cycle throughput under continuous ready.
- Back-pressure:
  - When valid&&!ready, event_axon_o and event_valid_o hold stable.
  - Pending does not change and the count does not change.
  - Valid never drops without a handshake.
- Last event:
  - A handshake that clears the final pending bit moves the block to DONE.
  - event_valid_o=0 in DONE.
- DONE:
  - done_o=1 for exactly one cycle, then go to IDLE.
  - spike_count_o holds its final value until the next start.
- start_i in SCAN or DONE is ignored; it is not queued.
- busy_o=1 in SCAN and DONE, 0 in IDLE.
- Empty vector: start, then DONE on the next cycle with done_o pulse, count=0, no valid ever asserted.
- All 256 bits set: 256 events, indices 0..255, count=256 (9-bit, no wrap), done_o after the final handshake.
- Index 255 must be emitted correctly; no off-by-one at the MSB.
- Reset mid-SCAN: pending is discarded, no done_o, and the block restarts only on a new start_i.
- event_axon_o value when event_valid_o=0 is don't-care, but must be 0 after reset.

Test Plan:
- Reset, then start with vector bits {3,17,255} set, ready held 1 -> valid on cycles 1,2,3 with axon 3,17,255; done_o pulse on cycle 4; spike_count_o=3; busy_o low on cycle 5.
- Start with vector=0 -> no event_valid_o; done_o pulse the cycle after start; spike_count_o=0.
- Bits {0,1} set, ready low for 5 cycles after valid -> axon 0 held stable with valid=1 for 5 cycles, count=0; after ready goes high, events 0 then 1, count=2.
- Start with all ones, ready=1 -> 256 consecutive events, indices 0..255 ascending; spike_count_o=256; done_o one cycle.
- Bits {10,20}; change spike_axon_i to bit {5} and pulse start_i again mid-SCAN -> only 10 and 20 emitted, second start ignored, count=2.
- Bits {7,8,9}; assert wb_rst_i asynchronously after the first handshake -> outputs reset immediately with no done_o; a new start with bit {2} yields a single event axon 2 and count=1.
